// File: rtl/fht_but_ctrl_if.sv
// Control/address bundle between the FHT butterfly sequencer and the
// datapath that owns the ping-pong RAM banks and twiddle ROM.
interface fht_but_ctrl_if #(
    parameter int LOG2N = 8,
    parameter int STG_W = 3
);
    logic             iSTART;
    logic             oRDY;
    logic             oRD_EN;
    logic [LOG2N-1:0] oRD_ADDR_0;
    logic [LOG2N-1:0] oRD_ADDR_1;
    logic [LOG2N-1:0] oRD_ADDR_2;
    logic [LOG2N-2:0] oROM_ADDR;
    logic             oRD_BANK;
    logic             oWR_EN;
    logic [LOG2N-1:0] oWR_ADDR_0;
    logic [LOG2N-1:0] oWR_ADDR_1;
    logic             oWR_BANK;
    logic [STG_W-1:0] oSTAGE;
    logic             oDONE;

    modport master (
        output iSTART,
        input  oRDY, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
               oRD_BANK, oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_BANK, oSTAGE, oDONE
    );

    modport slave (
        input  iSTART,
        output oRDY, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
               oRD_BANK, oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_BANK, oSTAGE, oDONE
    );
endinterface

// File: rtl/fht_but_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 FHT: issues one butterfly
// read per cycle, delays it into a matching write, and flushes between stages.
module fht_but_ctrl #(
    parameter int LOG2N  = 8,
    parameter int WR_DLY = 3,
    parameter int STG_W  = 3
) (
    input logic        iCLK,
    input logic        iRESET,
    fht_but_ctrl_if.slave bus
);
    localparam int K_W  = LOG2N - 1;
    localparam int FL_W = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;
    localparam logic [K_W-1:0]   K_LAST  = '1;
    localparam logic [STG_W-1:0] S_LAST  = STG_W'(LOG2N - 1);
    localparam logic [FL_W-1:0]  FL_LAST = FL_W'(WR_DLY - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a0;
        logic [LOG2N-1:0] a1;
        logic [LOG2N-1:0] a2;
        logic [K_W-1:0]   rom;
    } bfly_t;

    // k - j equals h*g, so doubling it gives the group base 2hg without a
    // variable shift by s+1 that could overflow the stage width.
    function automatic bfly_t bfly_addr(input logic [STG_W-1:0] stg, input logic [K_W-1:0] idx);
        logic [LOG2N-1:0] h, kx, j, base;
        bfly_t r;
        h      = LOG2N'(1) << stg;
        kx     = {1'b0, idx};
        j      = kx & (h - LOG2N'(1));
        base   = (kx - j) << 1;
        r.a0   = base | j;
        r.a1   = r.a0 + h;
        r.a2   = base + h + ((h - j) & (h - LOG2N'(1)));
        r.rom  = K_W'(j << (S_LAST - stg));
        return r;
    endfunction

    state_t           state;
    logic [K_W-1:0]   k;
    logic [STG_W-1:0] s;
    logic [FL_W-1:0]  fl_cnt;
    logic             rdy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_0, rd_addr_1, rd_addr_2;
    logic [K_W-1:0]   rom_addr;
    logic             rd_bank;

    logic             wr_vld    [WR_DLY];
    logic [LOG2N-1:0] wr_addr_0 [WR_DLY];
    logic [LOG2N-1:0] wr_addr_1 [WR_DLY];
    logic             wr_bank   [WR_DLY];

    logic             issue;
    logic [STG_W-1:0] nxt_s;
    logic [K_W-1:0]   nxt_k;
    bfly_t            nxt;

    // Decide whether the coming cycle carries a read, and for which (s, k).
    always_comb begin
        issue = 1'b0;
        nxt_s = s;
        nxt_k = k + K_W'(1);
        case (state)
            IDLE: begin
                issue = bus.iSTART;
                nxt_s = '0;
                nxt_k = '0;
            end
            RUN:   issue = (k != K_LAST);
            FLUSH: begin
                issue = (fl_cnt == FL_LAST) && (s != S_LAST);
                nxt_s = s + STG_W'(1);
                nxt_k = '0;
            end
            default: issue = 1'b0;
        endcase
    end

    assign nxt = bfly_addr(nxt_s, nxt_k);

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state     <= IDLE;
            k         <= '0;
            s         <= '0;
            fl_cnt    <= '0;
            rdy       <= 1'b1;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_0 <= '0;
            rd_addr_1 <= '0;
            rd_addr_2 <= '0;
            rom_addr  <= '0;
            rd_bank   <= 1'b0;
            for (int i = 0; i < WR_DLY; i++) begin
                wr_vld[i]    <= 1'b0;
                wr_addr_0[i] <= '0;
                wr_addr_1[i] <= '0;
                wr_bank[i]   <= 1'b0;
            end
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;

            // Write side: the butterfly result lands WR_DLY cycles after its read,
            // into the opposite bank.
            wr_vld[0]    <= rd_en;
            wr_addr_0[0] <= rd_addr_0;
            wr_addr_1[0] <= rd_addr_1;
            wr_bank[0]   <= ~rd_bank;
            for (int i = 1; i < WR_DLY; i++) begin
                wr_vld[i]    <= wr_vld[i-1];
                wr_addr_0[i] <= wr_addr_0[i-1];
                wr_addr_1[i] <= wr_addr_1[i-1];
                wr_bank[i]   <= wr_bank[i-1];
            end

            if (issue) begin
                rd_en     <= 1'b1;
                rd_addr_0 <= nxt.a0;
                rd_addr_1 <= nxt.a1;
                rd_addr_2 <= nxt.a2;
                rom_addr  <= nxt.rom;
                rd_bank   <= nxt_s[0];
                k         <= nxt_k;
                s         <= nxt_s;
            end

            case (state)
                IDLE: if (bus.iSTART) begin
                    state <= RUN;
                    rdy   <= 1'b0;
                end
                RUN: if (k == K_LAST) begin
                    state  <= FLUSH;
                    fl_cnt <= '0;
                    k      <= '0;
                end
                FLUSH: if (fl_cnt == FL_LAST) begin
                    if (s == S_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end else begin
                    fl_cnt <= fl_cnt + FL_W'(1);
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    s     <= '0;
                end
            endcase
        end
    end

    assign bus.oRDY       = rdy;
    assign bus.oRD_EN     = rd_en;
    assign bus.oRD_ADDR_0 = rd_addr_0;
    assign bus.oRD_ADDR_1 = rd_addr_1;
    assign bus.oRD_ADDR_2 = rd_addr_2;
    assign bus.oROM_ADDR  = rom_addr;
    assign bus.oRD_BANK   = rd_bank;
    assign bus.oWR_EN     = wr_vld[WR_DLY-1];
    assign bus.oWR_ADDR_0 = wr_addr_0[WR_DLY-1];
    assign bus.oWR_ADDR_1 = wr_addr_1[WR_DLY-1];
    assign bus.oWR_BANK   = wr_bank[WR_DLY-1];
    assign bus.oSTAGE     = s;
    assign bus.oDONE      = done;
endmodule

// File: doc/fht_but_ctrl.md
FHT_BUT_CTRL -- requirements
Module: fht_but_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 8, log2 of transform length N (N = 2^LOG2N, LOG2N >= 2).
REQ-002 SHALL have parameter WR_DLY, default 3, cycles from read issue to butterfly result valid (1 RAM read + 2 butterfly registers).
REQ-003 SHALL have parameter STG_W, default 3, width of stage index (2^STG_W >= LOG2N).
REQ-004 SHALL have port iCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port iRESET  input  1  reset is synchronous and active-low.
REQ-006 SHALL have port iSTART  input  1  one-cycle request to run a full transform.
REQ-007 SHALL have port oRDY  output  1  high while idle; iSTART accepted only when high.
REQ-008 SHALL have port oRD_EN  output  1  read strobe to data RAM bank.
REQ-009 SHALL have ports oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2  output  LOG2N each  read addresses for butterfly inputs x0, x1, x2.
REQ-010 SHALL have port oROM_ADDR  output  LOG2N-1  twiddle ROM address (sin/cos pair).
REQ-011 SHALL have port oRD_BANK  output  1  ping-pong bank being read.
REQ-012 SHALL have port oWR_EN  output  1  write strobe for butterfly outputs.
REQ-013 SHALL have ports oWR_ADDR_0, oWR_ADDR_1  output  LOG2N each  write addresses for y0, y1.
REQ-014 SHALL have port oWR_BANK  output  1  ping-pong bank being written.
REQ-015 SHALL have port oSTAGE  output  STG_W  current stage s, 0..LOG2N-1.
REQ-016 SHALL have port oDONE  output  1  one-cycle pulse when the last write of the last stage has completed.

Function
REQ-017 SHALL implement FSM IDLE, RUN, FLUSH, DONE; IDLE->RUN on iSTART, RUN->FLUSH after N/2 butterflies, FLUSH->RUN (s+1) or ->DONE (s = LOG2N-1) after WR_DLY cycles, DONE->IDLE after one cycle.
REQ-018 SHALL drive oRDY = 1 only in IDLE; iSTART outside IDLE SHALL be ignored.
REQ-019 SHALL issue exactly one butterfly per RUN cycle with oRD_EN=1, index k counting 0..N/2-1; first oRD_EN in the cycle after iSTART is sampled.
REQ-020 SHALL compute, for stage s with h = 2^s, g = k>>s, j = k mod h: ADDR_0 = 2hg + j; ADDR_1 = ADDR_0 + h; ADDR_2 = 2hg + h + ((h - j) mod h); ROM = j << (LOG2N-1-s).
REQ-021 SHALL register all read-side outputs (addresses, oROM_ADDR, oRD_EN, oRD_BANK) so they change only on clock edges.
REQ-022 SHALL drive oRD_BANK = s[0] and oWR_BANK = inverse of the read bank of the butterfly being written.
REQ-023 SHALL assert oWR_EN exactly WR_DLY cycles after each oRD_EN, with oWR_ADDR_0/1 equal to that butterfly's ADDR_0/ADDR_1, via a WR_DLY-deep shift pipeline.
REQ-024 SHALL hold RUN of stage s+1 until FLUSH completes, so no read of a bank occurs while writes to it are outstanding.
REQ-025 SHALL drive oRD_EN = 0 in IDLE, FLUSH, DONE; oWR_EN may be 1 only in RUN (after the first WR_DLY cycles of a stage) and FLUSH.
REQ-026 SHALL pulse oDONE for exactly one cycle in DONE, LOG2N*(N/2+WR_DLY)+1 cycles after the iSTART sampling edge.
REQ-027 SHALL hold oSTAGE at s through RUN and FLUSH of stage s; 0 in IDLE.
REQ-028 SHALL wrap k to 0 and s to 0 without overflow beyond declared widths; for s = 0, ROM = 0 and ADDR_2 = ADDR_1.

Reset
REQ-029 SHALL, on iCLK edge with iRESET = 0, enter IDLE and clear k, s, write pipeline, and all registered outputs to 0; oRDY = 1 from the first cycle after reset.
REQ-030 SHALL, on reset mid-transform, abort immediately: no oWR_EN, oRD_EN or oDONE in the following cycle, pending pipeline writes discarded.
REQ-031 SHALL give reset priority over iSTART in the same cycle.

Verification (LOG2N = 4, WR_DLY = 3)
REQ-032 SHALL verify: iSTART at cycle 0 -> cycle 1 oRD_EN=1, ADDR 0/1/1, ROM 0, oRD_BANK 0; cycle 4 oWR_EN=1, WR_ADDR 0/1, oWR_BANK 1.
REQ-033 SHALL verify: stage 1, k=1 -> ADDR 1/3/3, ROM 4; stage 3, k=3 -> ADDR 3/11/13, ROM 3, oRD_BANK 1.
REQ-034 SHALL verify: full run -> 32 oRD_EN pulses, 32 oWR_EN pulses, oDONE alone at cycle 45, oRDY=1 at cycle 46.
REQ-035 SHALL verify: iSTART repeated at cycles 5 and 20 of a run -> ignored, timing identical to single start.
REQ-036 SHALL verify: iRESET=0 at cycle 15 -> cycle 16 all strobes 0, oSTAGE 0, oRDY 1; new iSTART then produces a clean full run.
REQ-037 SHALL verify: back-to-back iSTART at the cycle oRDY returns -> second run starts with stage 0 bank 0, no overlap of writes from the first.
